halt_trace_monitor: RTL and testbench

HALT_TRACE_MONITOR -- requirements
Module: halt_trace_monitor

---
 rtl/halt_trace_monitor_if.sv | 34 +++
 rtl/halt_trace_monitor.sv | 149 ++++++++++++++
 tb/tb_halt_trace_monitor.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/halt_trace_monitor_if.sv
// Bus bundle for the halt/trace monitor: run control,
// retire stream, trace readback and status.
interface halt_trace_monitor_if #(
    parameter int DBITS = 32,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             start;
    logic             valid_in;
    logic [DBITS-1:0] inst_word_in;
    logic [DBITS-1:0] pc_in;
    logic [AW-1:0]    rd_idx;
    logic [DBITS-1:0] rd_data;
    logic [AW:0]      trace_count;
    logic [31:0]      cycle_count;
    logic [31:0]      instr_count;
    logic [DBITS-1:0] halt_pc;
    logic             busy;
    logic             done;
    logic             timed_out;

    modport master (
        output start, valid_in, inst_word_in, pc_in, rd_idx,
        input  rd_data, trace_count, cycle_count, instr_count,
        input  halt_pc, busy, done, timed_out
    );

    modport slave (
        input  start, valid_in, inst_word_in, pc_in, rd_idx,
        output rd_data, trace_count, cycle_count, instr_count,
        output halt_pc, busy, done, timed_out
    );
endinterface

// File: rtl/halt_trace_monitor.sv
// Run monitor: traces retired PCs into a circular buffer,
// counts cycles/instructions and stops on halt or timeout.
module halt_trace_monitor #(
    parameter int               DBITS     = 32,
    parameter int               DEPTH     = 16,
    parameter logic [DBITS-1:0] HALT_WORD = 'h0000DEAD,
    parameter int               SETTLE    = 2,
    parameter int               TIMEOUT   = 1024
) (
    input logic                 clk,
    input logic                 reset,
    halt_trace_monitor_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_SETTLE, S_DONE, S_TOUT
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      cyc_q, cyc_d;
    logic [31:0]      ins_q, ins_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    wp_q, wp_d;
    logic [DBITS-1:0] hpc_q, hpc_d;
    logic [31:0]      set_q, set_d;
    logic [DBITS-1:0] rd_q, rd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tout_q, tout_d;
    logic             we;
    logic             is_halt;
    logic [AW-1:0]    oldest;
    logic [AW-1:0]    ridx;

    logic [DBITS-1:0] mem_q [DEPTH];

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    assign is_halt = bus.valid_in && (bus.inst_word_in == HALT_WORD);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ins_d   = ins_q;
        cnt_d   = cnt_q;
        wp_d    = wp_q;
        hpc_d   = hpc_q;
        set_d   = set_q;
        we      = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_TOUT: begin
                if (bus.start) begin
                    cyc_d   = '0;
                    ins_d   = '0;
                    cnt_d   = '0;
                    wp_d    = '0;
                    hpc_d   = '0;
                    set_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cyc_d = sat_inc(cyc_q);
                if (bus.valid_in) begin
                    we    = 1'b1;
                    ins_d = sat_inc(ins_q);
                    wp_d  = wp_q + 1'b1;
                    if (cnt_q != CW'(DEPTH))
                        cnt_d = cnt_q + 1'b1;
                end
                // A halt on the timeout edge wins over the timeout.
                if (is_halt) begin
                    hpc_d   = bus.pc_in;
                    set_d   = '0;
                    state_d = (SETTLE == 0) ? S_DONE : S_SETTLE;
                end else if (TIMEOUT != 0 && cyc_d == 32'(TIMEOUT)) begin
                    state_d = S_TOUT;
                end
            end
            S_SETTLE: begin
                cyc_d = sat_inc(cyc_q);
                if (set_q == 32'(SETTLE - 1))
                    state_d = S_DONE;
                else
                    set_d = set_q + 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Once the buffer is full the write pointer sits on the oldest entry.
    assign oldest = (cnt_q == CW'(DEPTH)) ? wp_q : '0;
    assign ridx   = oldest + bus.rd_idx;

    always_comb begin
        rd_d   = '0;
        if ({1'b0, bus.rd_idx} < cnt_q)
            rd_d = mem_q[ridx];
        busy_d = (state_d == S_RUN) || (state_d == S_SETTLE);
        done_d = (state_d == S_DONE);
        tout_d = (state_d == S_TOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            ins_q   <= '0;
            cnt_q   <= '0;
            wp_q    <= '0;
            hpc_q   <= '0;
            set_q   <= '0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
            hpc_q   <= hpc_d;
            set_q   <= set_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem_q[wp_q] <= bus.pc_in;
    end

    assign bus.rd_data     = rd_q;
    assign bus.trace_count = cnt_q;
    assign bus.cycle_count = cyc_q;
    assign bus.instr_count = ins_q;
    assign bus.halt_pc     = hpc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timed_out   = tout_q;
endmodule

// File: tb/tb_halt_trace_monitor.sv
// Directed bench for halt_trace_monitor with DEPTH=4,
// SETTLE=2, TIMEOUT=16.
module tb_halt_trace_monitor;
    localparam logic [31:0] HALT = 32'h0000DEAD;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    halt_trace_monitor_if #(.DBITS(32), .DEPTH(4)) bus ();

    halt_trace_monitor #(
        .DBITS(32), .DEPTH(4), .HALT_WORD(HALT),
        .SETTLE(2), .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] iw);
        bus.valid_in     = 1'b1;
        bus.pc_in        = pc;
        bus.inst_word_in = iw;
        step();
        bus.valid_in     = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.valid_in     = 1'b0;
        bus.inst_word_in = '0;
        bus.pc_in        = '0;
        bus.rd_idx       = '0;
        #3;
        reset = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_cyc", 64'(bus.cycle_count), 64'd0);
        chk("rst_trace", 64'(bus.trace_count), 64'd0);
        step();

        // Halt run
        do_start();
        chk("h_busy0", 64'(bus.busy), 64'd1);
        chk("h_cyc0", 64'(bus.cycle_count), 64'd0);
        retire(32'h0, NOP);
        retire(32'h4, NOP);
        retire(32'h8, NOP);
        retire(32'hC, HALT);
        chk("h_hpc", 64'(bus.halt_pc), 64'hC);
        chk("h_instr", 64'(bus.instr_count), 64'd4);
        chk("h_trace", 64'(bus.trace_count), 64'd4);
        chk("h_busy_k", 64'(bus.busy), 64'd1);
        chk("h_done_k", 64'(bus.done), 64'd0);
        step();
        chk("h_done_k1", 64'(bus.done), 64'd0);
        step();
        chk("h_done_k2", 64'(bus.done), 64'd1);
        chk("h_busy_k2", 64'(bus.busy), 64'd0);
        chk("h_cyc_k2", 64'(bus.cycle_count), 64'd6);
        bus.rd_idx = 2'd3;
        step();
        chk("h_rd3", 64'(bus.rd_data), 64'hC);
        bus.rd_idx = 2'd1;
        step();
        chk("h_rd1", 64'(bus.rd_data), 64'h4);
        chk("h_hold_done", 64'(bus.done), 64'd1);
        chk("h_hold_cyc", 64'(bus.cycle_count), 64'd6);

        // Wrap run, then start ignored, then timeout
        bus.rd_idx = 2'd0;
        do_start();
        chk("w_trace0", 64'(bus.trace_count), 64'd0);
        chk("w_hpc0", 64'(bus.halt_pc), 64'd0);
        chk("w_done0", 64'(bus.done), 64'd0);
        step();
        chk("w_rd_empty", 64'(bus.rd_data), 64'd0);
        for (int i = 0; i < 6; i++)
            retire(32'(i * 4), NOP);
        chk("w_trace", 64'(bus.trace_count), 64'd4);
        chk("w_instr", 64'(bus.instr_count), 64'd6);
        bus.rd_idx = 2'd0;
        step();
        chk("w_rd0", 64'(bus.rd_data), 64'h8);
        bus.rd_idx = 2'd1;
        step();
        chk("w_rd1", 64'(bus.rd_data), 64'hC);
        bus.rd_idx = 2'd2;
        step();
        chk("w_rd2", 64'(bus.rd_data), 64'h10);
        bus.rd_idx = 2'd3;
        step();
        chk("w_rd3", 64'(bus.rd_data), 64'h14);
        do_start();
        chk("w_ign_busy", 64'(bus.busy), 64'd1);
        chk("w_ign_cyc", 64'(bus.cycle_count), 64'd12);
        chk("w_ign_instr", 64'(bus.instr_count), 64'd6);
        repeat (3) step();
        chk("w_tout15", 64'(bus.timed_out), 64'd0);
        step();
        chk("w_tout16", 64'(bus.timed_out), 64'd1);
        chk("w_busy16", 64'(bus.busy), 64'd0);

        // Pure timeout
        do_start();
        chk("t_cyc0", 64'(bus.cycle_count), 64'd0);
        chk("t_tout0", 64'(bus.timed_out), 64'd0);
        repeat (15) step();
        chk("t_cyc15", 64'(bus.cycle_count), 64'd15);
        chk("t_tout15", 64'(bus.timed_out), 64'd0);
        step();
        chk("t_tout16", 64'(bus.timed_out), 64'd1);
        chk("t_cyc16", 64'(bus.cycle_count), 64'd16);
        chk("t_done", 64'(bus.done), 64'd0);
        chk("t_busy", 64'(bus.busy), 64'd0);
        step();
        chk("t_hold_cyc", 64'(bus.cycle_count), 64'd16);

        // Halt on the timeout edge
        do_start();
        repeat (15) step();
        retire(32'h40, HALT);
        chk("c_tout", 64'(bus.timed_out), 64'd0);
        chk("c_busy", 64'(bus.busy), 64'd1);
        chk("c_hpc", 64'(bus.halt_pc), 64'h40);
        chk("c_instr", 64'(bus.instr_count), 64'd1);
        step();
        step();
        chk("c_done", 64'(bus.done), 64'd1);
        chk("c_tout2", 64'(bus.timed_out), 64'd0);
        chk("c_cyc", 64'(bus.cycle_count), 64'd18);

        // Abort with reset, then restart
        do_start();
        retire(32'h20, NOP);
        retire(32'h24, NOP);
        retire(32'h28, NOP);
        chk("a_instr3", 64'(bus.instr_count), 64'd3);
        #1;
        reset = 1'b1;
        #1;
        chk("a_busy", 64'(bus.busy), 64'd0);
        chk("a_done", 64'(bus.done), 64'd0);
        chk("a_tout", 64'(bus.timed_out), 64'd0);
        chk("a_cyc", 64'(bus.cycle_count), 64'd0);
        chk("a_instr", 64'(bus.instr_count), 64'd0);
        chk("a_trace", 64'(bus.trace_count), 64'd0);
        chk("a_hpc", 64'(bus.halt_pc), 64'd0);
        chk("a_rd", 64'(bus.rd_data), 64'd0);
        #1;
        reset = 1'b0;
        step();
        chk("a_idle_done", 64'(bus.done), 64'd0);
        chk("a_idle_tout", 64'(bus.timed_out), 64'd0);
        chk("a_idle_busy", 64'(bus.busy), 64'd0);
        do_start();
        retire(32'h100, NOP);
        chk("r_instr", 64'(bus.instr_count), 64'd1);
        chk("r_trace", 64'(bus.trace_count), 64'd1);
        chk("r_cyc", 64'(bus.cycle_count), 64'd1);
        bus.rd_idx = 2'd0;
        step();
        chk("r_rd0", 64'(bus.rd_data), 64'h100);
        bus.rd_idx = 2'd1;
        step();
        chk("r_rd1_masked", 64'(bus.rd_data), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
